// File: rtl/neuron_core_pkg.sv
// neuron_core_pkg: shared sizing, sequencer state encoding and beat flag constants for the neuron core
package neuron_core_pkg;

    localparam int NUM_AXONS  = 256;
    localparam int AXON_IDX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NEW  = 2'd1,
        ST_BODY = 2'd2,
        ST_LAST = 2'd3
    } seq_state_e;

    // Beat flags packed as {last_image_packet, new_image_packet}
    localparam logic [1:0] BEAT_FLAG_NONE = 2'b00;
    localparam logic [1:0] BEAT_FLAG_NEW  = 2'b01;
    localparam logic [1:0] BEAT_FLAG_LAST = 2'b10;

endpackage

// File: rtl/lsb_priority_enc.sv
// lsb_priority_enc: index of the lowest set bit of a vector plus an any-bit-set flag
module lsb_priority_enc #(
    parameter int N = 256,
    parameter int W = 8
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    assign any_o = |vec_i;

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--)
            if (vec_i[i]) idx_o = i[W-1:0];
    end

endmodule

// File: rtl/axon_spike_sequencer.sv
// axon_spike_sequencer: replays a latched axon spike frame as an ascending beat stream ending in a null evaluate beat
// Optional AXON_SEQ_PERF_CNT_EN adds frame_cnt_o and spike_cnt_o performance counters.
module axon_spike_sequencer #(
    parameter int NUM_AXONS  = neuron_core_pkg::NUM_AXONS,
    parameter int AXON_IDX_W = neuron_core_pkg::AXON_IDX_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_AXONS-1:0]  spike_vec_i,
    input  logic                  spike_valid_i,
    output logic                  spike_ready_o,
    output logic                  beat_valid_o,
    input  logic                  beat_ready_i,
    output logic [AXON_IDX_W-1:0] axon_idx_o,
    output logic                  null_o,
    output logic                  new_image_packet_o,
    output logic                  last_image_packet_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef AXON_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]           frame_cnt_o,
    output logic [8:0]            spike_cnt_o
`endif
);

    import neuron_core_pkg::*;

    seq_state_e            r_state;
    logic [NUM_AXONS-1:0]  r_pending;
    logic                  r_done;
    logic [AXON_IDX_W-1:0] w_idx;
    logic                  w_any;
    logic [NUM_AXONS-1:0]  w_cleared;
    logic [1:0]            w_flags;
    logic                  w_beat_hs;

    lsb_priority_enc #(
        .N (NUM_AXONS),
        .W (AXON_IDX_W)
    ) u_lsb_enc (
        .vec_i (r_pending),
        .idx_o (w_idx),
        .any_o (w_any)
    );

    // Dropping the lowest set bit is the same bit the encoder reports
    assign w_cleared = r_pending & (r_pending - NUM_AXONS'(1));
    assign w_beat_hs = beat_valid_o & beat_ready_i;
    assign w_flags   = r_state == ST_NEW  ? BEAT_FLAG_NEW  :
                       r_state == ST_LAST ? BEAT_FLAG_LAST : BEAT_FLAG_NONE;

    assign {last_image_packet_o, new_image_packet_o} = w_flags;
    assign spike_ready_o = r_state == ST_IDLE;
    assign beat_valid_o  = r_state != ST_IDLE;
    assign busy_o        = r_state != ST_IDLE;
    assign axon_idx_o    = w_idx;
    assign null_o        = (r_state == ST_LAST) | ((r_state == ST_NEW) & ~w_any);
    assign done_o        = r_done;

    // Frame sequencing: accept in IDLE, walk set bits in NEW/BODY, finish with the LAST beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (spike_valid_i) begin
                    r_pending <= spike_vec_i;
                    r_state   <= ST_NEW;
                end
                ST_NEW, ST_BODY: if (beat_ready_i) begin
                    r_pending <= w_cleared;
                    r_state   <= |w_cleared ? ST_BODY : ST_LAST;
                end
                default: if (beat_ready_i) begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AXON_SEQ_PERF_CNT_EN
    logic [15:0] r_frame_cnt;
    logic [8:0]  r_spike_cnt;
    logic [8:0]  r_spike_run;

    assign frame_cnt_o = r_frame_cnt;
    assign spike_cnt_o = r_spike_run == r_spike_run ? r_spike_cnt : r_spike_cnt;

    // Count non-null beats of the running frame and publish them with the frame count on completion
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frame_cnt <= '0;
            r_spike_cnt <= '0;
            r_spike_run <= '0;
        end else if (w_beat_hs & last_image_packet_o) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_spike_cnt <= r_spike_run;
            r_spike_run <= '0;
        end else if (w_beat_hs & ~null_o) begin
            r_spike_run <= r_spike_run + 9'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_beat_hs;
`endif

endmodule

// File: doc/axon_spike_sequencer.md
# axon_spike_sequencer

Front end of the 256x256 neuron core: accepts one image frame of axon spikes as a 256-bit vector and replays it as the beat stream the neuron blocks consume. Each beat carries an axon index plus new-image/last-image flags. The first beat of a frame is flagged new, and the final beat is a null (zero-weight) last beat that triggers leak, threshold and spike evaluation. Output beats are flow-controlled so the synapse-row memory can stall the stream.

## Interface
Parameters:
- NUM_AXONS, 256, axons per frame / width of spike vector
- AXON_IDX_W, 8, width of axon index (log2 NUM_AXONS)

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  reset; asynchronous, active-low
- spike_vec_i  input  NUM_AXONS  axon spike vector, bit i = axon i fired
- spike_valid_i  input  1  frame offered
- spike_ready_o  output  1  frame accepted when valid&ready
- beat_valid_o  output  1  beat present
- beat_ready_i  input  1  downstream takes beat when valid&ready
- axon_idx_o  output  AXON_IDX_W  axon whose synapse row/weight_select applies
- null_o  output  1  beat carries zero weight; downstream forces weight to 0
- new_image_packet_o  output  1  first beat of frame
- last_image_packet_o  output  1  final (evaluate) beat of frame
- busy_o  output  1  frame in progress
- done_o  output  1  one-cycle pulse after last beat handshake

## Operation
- FSM states: IDLE, NEW, BODY, LAST.
- IDLE: spike_ready_o=1; on valid&ready latch spike_vec_i into pending register, go NEW. No other state asserts spike_ready_o.
- NEW: beat_valid_o=1, new_image_packet_o=1.
  - axon_idx_o = lowest set bit of pending, null_o=0.
  - If pending==0: axon_idx_o=0, null_o=1.
  - On handshake: clear that bit; go BODY if remaining pending nonzero, else LAST.
- BODY: beat_valid_o=1, both flags 0, axon_idx_o = lowest set bit, null_o=0. On handshake clear bit; go LAST when cleared pending becomes 0.
- LAST: beat_valid_o=1, last_image_packet_o=1, null_o=1, axon_idx_o=0. On handshake pulse done_o next cycle, go IDLE.
- new and last are never asserted in the same beat.
- Beat count per frame = max(K,1)+1, where K = popcount(spike_vec_i).
- Axon order is strictly ascending index. Each set bit is emitted exactly once.
- While beat_valid_o && !beat_ready_i, all beat outputs hold stable.
- busy_o = (state != IDLE).

## Timing
- Reset: state IDLE, pending=0. spike_ready_o=1 after reset deassertion. All other outputs 0.
- Frame accepted at edge T: first beat valid in cycle T+1 (1-cycle latency).
- With beat_ready_i held high: one beat per cycle, no bubbles. done_o is asserted the cycle after the LAST handshake. spike_ready_o rises in that same cycle, so the next frame can be accepted there.
- Lowest-set-bit selection is combinational from pending; no extra pipeline stage.
- Reset asserted mid-frame: immediate return to IDLE and the frame is discarded. No last beat is emitted; downstream must also reset.
- spike_vec_i is ignored when not handshaking; changes to it after acceptance have no effect.
- Axon 255 set alone: NEW beat idx 255, then LAST. No wrap past index 255.

## Configuration
- AXON_SEQ_PERF_CNT_EN defined: adds outputs frame_cnt_o (16 bit) and spike_cnt_o (9 bit).
  - frame_cnt_o increments on each done_o and wraps at 65535→0.
  - spike_cnt_o holds the non-null beat count of the most recently completed frame, updated with done_o.
  - Both reset to 0.
- Not defined: those ports and registers do not exist; behaviour is otherwise identical.

## Structure
- Shared package neuron_core_pkg:
  - NUM_AXONS, AXON_IDX_W
  - FSM state encoding (IDLE=0, NEW=1, BODY=2, LAST=3)
  - beat flag constants (reused by the neuron core array).
- One sub-module: lsb_priority_enc (NUM_AXONS-in, index + any-set out), instantiated once on pending.

## Test plan
- Frame 0x...05 (axons 0,2), ready high: beats (idx0,new), (idx2), (idx0,null,last); done_o pulse; total 3 beats in cycles T+1..T+3.
- Frame all-zero: beats (idx0,null,new), (idx0,null,last); done_o pulse.
- Frame with only bit 255, beat_ready_i low for 4 cycles in NEW: outputs stable idx255/new for those cycles, then LAST after ready rises.
- Frame all-ones: 256 non-null beats ascending 0..255 with new only on idx0, then null last beat; with AXON_SEQ_PERF_CNT_EN, spike_cnt_o=256 and frame_cnt_o=1 afterward.
- Back-to-back frames 0x1 then 0x2 with spike_valid_i held high: second frame accepted in the done_o cycle; beat stream (0,new),(null,last),(1,new),(null,last).
- Reset asserted during BODY of frame 0xF0: next cycle all outputs 0, spike_ready_o=1 after release, no last beat emitted; next frame 0x1 sequences normally.
